// File: rtl/img_get_grads_mul_arb.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier among NUM_REQ requesters.
// The requester tag rides along the pipeline, and results return on a shared bus with a one-hot valid.
module img_get_grads_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 18,
  parameter int DOUT_WIDTH = 36,
  parameter int MUL_STAGES = 3,
  localparam int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           ap_ce,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             res_valid,
  output logic [DOUT_WIDTH-1:0]          res_data,
  output logic [TAG_W-1:0]               res_tag,
  output logic                           ap_idle
);

  localparam int CNT_W = $clog2(MUL_STAGES + 1);
  localparam int LAST  = MUL_STAGES - 1;

  // Handshake: a transfer happens in a cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready is one-hot on the round-robin winner and only while ap_ce is high and reset is low.

  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  found;
  logic [TAG_W-1:0]      win;
  logic [NUM_REQ-1:0]    grant_oh;
  logic                  xfer;
  logic                  res_fire;
  logic [DIN_WIDTH-1:0]  sel_a, sel_b;

  logic [MUL_STAGES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]      tag_q [MUL_STAGES];
  logic [TAG_W-1:0]      tag_d [MUL_STAGES];
  logic [DOUT_WIDTH-1:0] dat_q [MUL_STAGES];
  logic [DOUT_WIDTH-1:0] dat_d [MUL_STAGES];

  function automatic logic [DOUT_WIDTH-1:0] mul_u(input logic [DIN_WIDTH-1:0] a,
                                                  input logic [DIN_WIDTH-1:0] b);
    return DOUT_WIDTH'(a) * DOUT_WIDTH'(b);
  endfunction

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first pending request wins.
  always_comb begin
    int  idx;
    logic vbit;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    vbit  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      vbit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == i) vbit = req_valid[i];
      end
      if (!found && vbit) begin
        found = 1'b1;
        win   = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == TAG_W'(i)) begin
        sel_a = req_a[i*DIN_WIDTH +: DIN_WIDTH];
        sel_b = req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
    if (found && ap_ce && !ap_rst) grant_oh[win] = 1'b1;
  end

  assign req_ready = grant_oh;
  assign xfer      = |(req_valid & grant_oh);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (win == TAG_W'(NUM_REQ - 1)) ? '0 : win + TAG_W'(1);
    end
  end

  // Stage 0 holds the raw operand pair (or the product when the pipe is one deep);
  // stage 1 forms the product, and later stages only delay it.
  always_comb begin
    vld_d[0] = xfer;
    tag_d[0] = win;
    dat_d[0] = (MUL_STAGES == 1) ? mul_u(sel_a, sel_b) : DOUT_WIDTH'({sel_a, sel_b});
    for (int s = 1; s < MUL_STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
      if (s == 1) begin
        dat_d[s] = mul_u(dat_q[0][2*DIN_WIDTH-1 -: DIN_WIDTH], dat_q[0][DIN_WIDTH-1:0]);
      end else begin
        dat_d[s] = dat_q[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
      for (int s = 0; s < MUL_STAGES; s++) begin
        tag_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else if (ap_ce) begin
      vld_q <= vld_d;
      for (int s = 0; s < MUL_STAGES; s++) begin
        tag_q[s] <= tag_d[s];
        dat_q[s] <= dat_d[s];
      end
    end
  end

  // Reset also masks the last stage so a result due in the reset cycle is discarded.
  assign res_fire = vld_q[LAST] && ap_ce && !ap_rst;

  always_comb begin
    res_valid = '0;
    if (res_fire) res_valid[tag_q[LAST]] = 1'b1;
  end

  assign res_data = dat_q[LAST];
  assign res_tag  = tag_q[LAST];

  always_comb begin
    case ({xfer, res_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (ap_ce) begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ap_idle = (cnt_q == '0) && (req_valid == '0);

endmodule

// File: tb/tb_img_get_grads_mul_arb.sv
// Directed and random stimulus for img_get_grads_mul_arb, with an arbiter model and a result
// scoreboard that tracks the remaining latency of each accepted operand pair.
module tb_img_get_grads_mul_arb;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int OW = 36;
  localparam int MS = 3;
  localparam int TW = 2;
  localparam int EW = TW + OW;

  logic            ap_clk = 1'b0;
  logic            ap_rst, ap_ce;
  logic [N-1:0]    req_valid, req_ready, res_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [OW-1:0]   res_data;
  logic [TW-1:0]   res_tag;
  logic            ap_idle;

  img_get_grads_mul_arb #(
    .NUM_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_STAGES(MS)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .ap_idle(ap_idle)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {tag, product} with enabled cycles left before it must appear
  logic [EW-1:0] exp_q[$];
  int            rem_q[$];
  int            mptr = 0;
  int            wait_cnt[N];
  bit            fair_on = 1'b0;
  logic [N-1:0]  last_grant;
  logic [N-1:0]  v;
  logic          r3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input int x0, input int x1, input int x2, input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  function automatic logic [N*DW-1:0] rand_ops();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return r;
  endfunction

  // driver: applies one cycle of inputs, checks outputs, advances the model
  task automatic step(input logic rst, input logic ce, input logic [N-1:0] vv,
                      input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_res;
    logic [EW-1:0] head;
    logic          exp_fire;
    int            w;
    ap_rst = rst; ap_ce = ce; req_valid = vv; req_a = a; req_b = b;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (w < 0 && vv[idx]) w = idx;
    end
    exp_rdy = '0;
    if (!rst && ce && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));

    exp_fire = !rst && ce && exp_q.size() > 0 && rem_q[0] == 0;
    head     = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_res  = '0;
    if (exp_fire) exp_res[head[EW-1 -: TW]] = 1'b1;
    chk("res_valid", 64'(res_valid), 64'(exp_res));
    if (exp_fire) begin
      chk("res_data", 64'(res_data), 64'(head[OW-1:0]));
      chk("res_tag", 64'(res_tag), 64'(head[EW-1 -: TW]));
    end
    if (!rst) chk("ap_idle", 64'(ap_idle), 64'(exp_q.size() == 0 && vv == '0));

    if (fair_on) begin
      for (int i = 0; i < N; i++) begin
        if (vv[i] && !req_ready[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk("fair_wait", 64'(wait_cnt[i] < N), 64'd1);
      end
    end
    last_grant = req_ready;

    if (rst) begin
      exp_q.delete();
      rem_q.delete();
      mptr = 0;
    end else if (ce) begin
      if (exp_fire) begin
        void'(exp_q.pop_front());
        void'(rem_q.pop_front());
      end
      foreach (rem_q[i]) if (rem_q[i] > 0) rem_q[i]--;
      if (w >= 0) begin
        exp_q.push_back({TW'(w), OW'(a[w*DW +: DW]) * OW'(b[w*DW +: DW])});
        rem_q.push_back(MS - 1);
        mptr = (w + 1) % N;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    ap_rst = 1'b1; ap_ce = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    step(1'b1, 1'b1, '0, '0, '0);
    step(1'b1, 1'b1, '0, '0, '0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);

    // single request: requester 2, 3*5
    idle(1);
    step(1'b0, 1'b1, 4'b0100, pack(0, 0, 3, 0), pack(0, 0, 5, 0));
    idle(5);

    // round robin from reset
    step(1'b1, 1'b1, '0, '0, '0);
    repeat (8) step(1'b0, 1'b1, 4'b1111, pack(1, 2, 3, 4), pack(10, 10, 10, 10));
    idle(4);

    // max operands
    step(1'b0, 1'b1, 4'b0001, pack(18'h3FFFF, 0, 0, 0), pack(18'h3FFFF, 0, 0, 0));
    idle(4);

    // stall with a result in flight and other requests pending
    step(1'b0, 1'b1, 4'b0010, pack(0, 7, 0, 0), pack(0, 9, 0, 0));
    step(1'b0, 1'b0, 4'b1001, pack(2, 0, 0, 6), pack(3, 0, 0, 4));
    step(1'b0, 1'b0, 4'b1001, pack(2, 0, 0, 6), pack(3, 0, 0, 4));
    step(1'b0, 1'b1, 4'b1001, pack(2, 0, 0, 6), pack(3, 0, 0, 4));
    step(1'b0, 1'b1, 4'b0001, pack(2, 0, 0, 6), pack(3, 0, 0, 4));
    idle(5);

    // reset while three results are in flight
    repeat (3) step(1'b0, 1'b1, 4'b1111, rand_ops(), rand_ops());
    step(1'b1, 1'b1, 4'b1111, rand_ops(), rand_ops());
    step(1'b0, 1'b1, 4'b1010, pack(0, 11, 0, 13), pack(0, 12, 0, 14));
    idle(5);

    // fairness: requester 1 always valid, requester 3 drops for one cycle after each grant
    step(1'b1, 1'b1, '0, '0, '0);
    fair_on = 1'b1;
    r3 = 1'b1;
    repeat (24) begin
      v[0] = 1'($urandom_range(0, 1));
      v[1] = 1'b1;
      v[2] = 1'($urandom_range(0, 1));
      v[3] = r3;
      step(1'b0, 1'b1, v, rand_ops(), rand_ops());
      r3 = !last_grant[3];
    end
    fair_on = 1'b0;
    idle(4);

    // random traffic with random clock-enable
    repeat (60) begin
      v = N'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 3) != 0), v, rand_ops(), rand_ops());
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
